rf_wport_arbiter: RTL and testbench

//   Shares the single register-file write port (we/rd/data into the ID stage) between the WB stage
//   and the long-latency MUL/DIV unit (MDU). WB always wins; MDU results queue in a small FIFO
//   and drain into idle WB slots. Provides a RAW-hazard flag for pending MDU destinations and a

---
 rtl/rf_wport_arbiter_if.sv | 33 +++
 rtl/rf_wport_arbiter.sv | 179 +++++++++++++++++
 tb/tb_rf_wport_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wport_arbiter_if.sv
// Handshake and write-port bundle between the pipeline, the MDU and the register-file arbiter.
interface rf_wport_arbiter_if #(
    parameter int DEPTH = 2
);
    logic                         i_wb_we;
    logic [4:0]                   i_wb_rd;
    logic [31:0]                  i_wb_data;
    logic                         i_mdu_valid;
    logic                         o_mdu_ready;
    logic [4:0]                   i_mdu_rd;
    logic [31:0]                  i_mdu_data;
    logic [4:0]                   i_rs1;
    logic [4:0]                   i_rs2;
    logic                         o_reg_we;
    logic [4:0]                   o_write_reg;
    logic [31:0]                  o_write_reg_data;
    logic [1:0]                   o_src;
    logic                         o_raw_hazard;
    logic                         o_stall_req;
    logic [$clog2(DEPTH+1)-1:0]   o_fifo_count;

    modport master (
        output i_wb_we, i_wb_rd, i_wb_data, i_mdu_valid, i_mdu_rd, i_mdu_data, i_rs1, i_rs2,
        input  o_mdu_ready, o_reg_we, o_write_reg, o_write_reg_data, o_src,
               o_raw_hazard, o_stall_req, o_fifo_count
    );

    modport slave (
        input  i_wb_we, i_wb_rd, i_wb_data, i_mdu_valid, i_mdu_rd, i_mdu_data, i_rs1, i_rs2,
        output o_mdu_ready, o_reg_we, o_write_reg, o_write_reg_data, o_src,
               o_raw_hazard, o_stall_req, o_fifo_count
    );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Shares the RF write port between WB (always wins) and queued MDU results; grant is same-cycle.
// MDU results need at least one cycle in the queue; o_mdu_ready drops when the queue is full.
module rf_wport_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    rf_wport_arbiter_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STALL} st_t;

    ent_t             ent_q [DEPTH];
    ent_t             ent_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] stale_q, stale_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    st_t              st_q, st_d;
    logic [SW-1:0]    cnt_q, cnt_d;

    logic        wb_act, head_vld, head_live, pop, push, ready_int;
    ent_t        head;
    logic        reg_we, raw_hazard;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [1:0]  src;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    function automatic logic src_hit(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
        return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

    // Results for x0 are marked stale on entry, so they drain without a write.
    assign wb_act    = bus.i_wb_we && (bus.i_wb_rd != 5'd0);
    assign head      = ent_q[rd_ptr_q];
    assign head_vld  = vld_q[rd_ptr_q];
    assign head_live = head_vld && !stale_q[rd_ptr_q];
    assign pop       = head_vld && !wb_act;
    assign ready_int = (count_q < CW'(DEPTH));
    assign push      = bus.i_mdu_valid && ready_int;

    always_comb begin
        ent_d    = ent_q;
        vld_d    = vld_q;
        stale_d  = stale_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        // A younger WB write to the same rd makes the queued result obsolete.
        for (int i = 0; i < DEPTH; i++) begin
            if (wb_act && vld_q[i] && (ent_q[i].rd == bus.i_wb_rd)) begin
                stale_d[i] = 1'b1;
            end
        end
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = ptr_inc(rd_ptr_q);
        end
        if (push) begin
            ent_d[wr_ptr_q]   = '{rd: bus.i_mdu_rd, data: bus.i_mdu_data};
            vld_d[wr_ptr_q]   = 1'b1;
            stale_d[wr_ptr_q] = (bus.i_mdu_rd == 5'd0);
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        if ((count_q == '0) || pop) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
        end else begin
            case (st_q)
                ST_IDLE, ST_WAIT: begin
                    if (head_live && wb_act) begin
                        cnt_d = cnt_q + SW'(1);
                        st_d  = (cnt_d >= SW'(STARVE_MAX)) ? ST_STALL : ST_WAIT;
                    end
                end
                default: begin
                    st_d  = st_q;
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    always_comb begin
        reg_we     = 1'b0;
        write_reg  = 5'd0;
        write_data = 32'd0;
        src        = 2'b00;
        raw_hazard = 1'b0;
        if (wb_act) begin
            reg_we     = 1'b1;
            write_reg  = bus.i_wb_rd;
            write_data = bus.i_wb_data;
            src        = 2'b01;
        end else if (head_live) begin
            reg_we     = 1'b1;
            write_reg  = head.rd;
            write_data = head.data;
            src        = 2'b10;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && !stale_q[i] && src_hit(ent_q[i].rd, bus.i_rs1, bus.i_rs2)) begin
                raw_hazard = 1'b1;
            end
        end
        if (push && src_hit(bus.i_mdu_rd, bus.i_rs1, bus.i_rs2)) begin
            raw_hazard = 1'b1;
        end
        // Reset is synchronous, so the outputs are squashed while it is held.
        if (!i_rstn) begin
            reg_we     = 1'b0;
            write_reg  = 5'd0;
            write_data = 32'd0;
            src        = 2'b00;
            raw_hazard = 1'b0;
        end
    end

    assign bus.o_reg_we         = reg_we;
    assign bus.o_write_reg      = write_reg;
    assign bus.o_write_reg_data = write_data;
    assign bus.o_src            = src;
    assign bus.o_raw_hazard     = raw_hazard;
    assign bus.o_mdu_ready      = ready_int || !i_rstn;
    assign bus.o_stall_req      = (st_q == ST_STALL) && i_rstn;
    assign bus.o_fifo_count     = count_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            vld_q    <= '0;
            stale_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            st_q     <= ST_IDLE;
            cnt_q    <= '0;
        end else begin
            vld_q    <= vld_d;
            stale_q  <= stale_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            st_q     <= st_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        ent_q <= ent_d;
    end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed plus randomized checks of the RF write-port arbiter against a queue-based reference.
module tb_rf_wport_arbiter;
    localparam int DEPTH = 2;
    localparam int SM    = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    rf_wport_arbiter_if #(.DEPTH(DEPTH)) bif ();

    rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bif)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          stale;
    } mq_t;

    mq_t         mq[$];
    int          run;
    bit          stall_m;
    bit          acc_m;
    int          n_assert;
    int          n_fail;
    logic [31:0] rf_obs [32];

    logic        s_we, s_rdy, s_haz, s_stall;
    logic [4:0]  s_reg;
    logic [31:0] s_data;
    logic [1:0]  s_src, s_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hitf(input logic [4:0] rd);
        return (rd != 5'd0) && ((rd == bif.i_rs1) || (rd == bif.i_rs2));
    endfunction

    task automatic drive(input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic [4:0] r1, input logic [4:0] r2);
        bif.i_wb_we     = we;
        bif.i_wb_rd     = wrd;
        bif.i_wb_data   = wd;
        bif.i_mdu_valid = mv;
        bif.i_mdu_rd    = mrd;
        bif.i_mdu_data  = md;
        bif.i_rs1       = r1;
        bif.i_rs2       = r2;
    endtask

    // Checks every output at the falling edge, then advances the reference by one clock.
    task automatic cycle();
        bit          wb_act, pop, push, blocked, empty;
        logic        e_we, e_haz;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        logic [1:0]  e_src;
        mq_t         ne;
        @(negedge clk);
        s_we    = bif.o_reg_we;
        s_reg   = bif.o_write_reg;
        s_data  = bif.o_write_reg_data;
        s_src   = bif.o_src;
        s_rdy   = bif.o_mdu_ready;
        s_haz   = bif.o_raw_hazard;
        s_stall = bif.o_stall_req;
        s_cnt   = bif.o_fifo_count;
        if (s_we === 1'b1) rf_obs[s_reg] = s_data;

        wb_act = bif.i_wb_we && (bif.i_wb_rd != 5'd0);
        e_we = 1'b0; e_reg = 5'd0; e_data = 32'd0; e_src = 2'b00; e_haz = 1'b0;
        pop = 1'b0; push = 1'b0;
        if (rstn) begin
            if (wb_act) begin
                e_we = 1'b1; e_reg = bif.i_wb_rd; e_data = bif.i_wb_data; e_src = 2'b01;
            end else if (mq.size() > 0) begin
                pop = 1'b1;
                if (!mq[0].stale && mq[0].rd != 5'd0) begin
                    e_we = 1'b1; e_reg = mq[0].rd; e_data = mq[0].data; e_src = 2'b10;
                end
            end
            push = bif.i_mdu_valid && (mq.size() < DEPTH);
            foreach (mq[i]) if (!mq[i].stale && hitf(mq[i].rd)) e_haz = 1'b1;
            if (push && hitf(bif.i_mdu_rd)) e_haz = 1'b1;
        end
        chk("reg_we", 32'(s_we), 32'(e_we));
        chk("write_reg", 32'(s_reg), 32'(e_reg));
        chk("write_data", s_data, e_data);
        chk("src", 32'(s_src), 32'(e_src));
        chk("mdu_ready", 32'(s_rdy), rstn ? 32'(mq.size() < DEPTH) : 32'd1);
        chk("raw_hazard", 32'(s_haz), 32'(e_haz));
        chk("stall_req", 32'(s_stall), rstn ? 32'(stall_m) : 32'd0);
        chk("fifo_count", 32'(s_cnt), 32'(mq.size()));

        if (!rstn) begin
            mq.delete();
            run = 0;
            stall_m = 1'b0;
        end else begin
            empty   = (mq.size() == 0);
            blocked = !empty && !mq[0].stale && (mq[0].rd != 5'd0) && wb_act;
            foreach (mq[i]) if (wb_act && mq[i].rd == bif.i_wb_rd) mq[i].stale = 1'b1;
            if (pop || empty) begin
                run = 0;
                stall_m = 1'b0;
            end else if (blocked) begin
                run++;
                if (run >= SM) stall_m = 1'b1;
            end
            if (pop) void'(mq.pop_front());
            if (push) begin
                ne.rd = bif.i_mdu_rd; ne.data = bif.i_mdu_data; ne.stale = 1'b0;
                mq.push_back(ne);
            end
        end
        acc_m = push;
        @(posedge clk);
        #1;
    endtask

    logic        mv_h;
    logic [4:0]  mrd_h;
    logic [31:0] md_h;

    initial begin
        n_assert = 0; n_fail = 0; run = 0; stall_m = 1'b0; acc_m = 1'b0;
        for (int i = 0; i < 32; i++) rf_obs[i] = 32'd0;

        // Reset held with WB requesting: port must stay silent.
        rstn = 1'b0;
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88, 5'd8, 5'd0);
        cycle();
        cycle();
        chk("rst_reg_we", 32'(s_we), 32'd0);
        chk("rst_ready", 32'(s_rdy), 32'd1);
        chk("rst_count", 32'(s_cnt), 32'd0);
        rstn = 1'b1;

        // WB write goes straight through.
        drive(1'b1, 5'd5, 32'hA, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        cycle();
        chk("t1_we", 32'(s_we), 32'd1);
        chk("t1_reg", 32'(s_reg), 32'd5);
        chk("t1_data", s_data, 32'hA);
        chk("t1_src", 32'(s_src), 32'd1);

        // MDU result writes one cycle after acceptance.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 5'd0, 5'd0);
        cycle();
        chk("t2_no_passthru", 32'(s_we), 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        cycle();
        chk("t2_src", 32'(s_src), 32'd2);
        chk("t2_reg", 32'(s_reg), 32'd7);
        chk("t2_data", s_data, 32'h77);
        chk("t2_count1", 32'(s_cnt), 32'd1);
        cycle();
        chk("t2_count0", 32'(s_cnt), 32'd0);

        // Fill the queue while WB is busy; third push must be held.
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd10, 32'h100, 5'd0, 5'd0);
        cycle();
        drive(1'b1, 5'd1, 32'h12, 1'b1, 5'd11, 32'h101, 5'd0, 5'd0);
        cycle();
        drive(1'b1, 5'd1, 32'h13, 1'b1, 5'd12, 32'h102, 5'd0, 5'd0);
        cycle();
        chk("t3_ready", 32'(s_rdy), 32'd0);
        chk("t3_count", 32'(s_cnt), 32'd2);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h102, 5'd0, 5'd0);
        cycle();
        chk("t3_head", 32'(s_reg), 32'd10);
        cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        cycle();
        chk("t3_third", s_data, 32'h102);
        cycle();

        // WB overwrite of a queued destination suppresses the older MDU write.
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h99, 5'd0, 5'd0);
        cycle();
        drive(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        cycle();
        chk("t4_we", 32'(s_we), 32'd0);
        chk("t4_src", 32'(s_src), 32'd0);
        cycle();
        chk("t4_x9", rf_obs[9], 32'h1);

        // Starvation: four blocked cycles raise the stall request.
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd20, 32'h200, 5'd0, 5'd0);
        cycle();
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        for (int b = 0; b < 4; b++) cycle();
        chk("t5_stall_b4", 32'(s_stall), 32'd0);
        cycle();
        chk("t5_stall_b5", 32'(s_stall), 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        cycle();
        chk("t5_stall_pop", 32'(s_stall), 32'd1);
        chk("t5_pop_src", 32'(s_src), 32'd2);
        cycle();
        chk("t5_stall_off", 32'(s_stall), 32'd0);

        // RAW hazard on a pending destination, then reset mid-queue.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h3, 5'd0, 5'd3);
        cycle();
        chk("t6_haz_push", 32'(s_haz), 32'd1);
        drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 5'd0, 5'd3);
        cycle();
        chk("t6_haz_queued", 32'(s_haz), 32'd1);
        rstn = 1'b0;
        cycle();
        chk("t6_rst_haz", 32'(s_haz), 32'd0);
        chk("t6_rst_we", 32'(s_we), 32'd0);
        rstn = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd3);
        cycle();
        chk("t6_count", 32'(s_cnt), 32'd0);
        chk("t6_haz", 32'(s_haz), 32'd0);
        chk("t6_we", 32'(s_we), 32'd0);

        // Random traffic; the MDU holds a result until it is accepted.
        mv_h = 1'b0; mrd_h = 5'd0; md_h = 32'd0; acc_m = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!mv_h || acc_m) begin
                mv_h  = ($urandom_range(0, 2) != 0);
                mrd_h = 5'($urandom_range(0, 7));
                md_h  = $urandom;
            end
            rstn = ($urandom_range(0, 79) != 0);
            drive(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                  mv_h, mrd_h, md_h, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
